// File: rtl/dual_shift_pkg.sv
// Shared types and constants for the dual shift register command sequencer.
package dual_shift_pkg;

  localparam int unsigned DSR_WIDTH = 8;
  localparam int unsigned DSR_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [DSR_WIDTH-1:0] data0;
    logic [DSR_WIDTH-1:0] data1;
    logic [1:0]           mask;
    logic [DSR_CNT_W-1:0] shamt;
  } seq_cmd_t;

  // A shift count larger than the byte width is equivalent to a full flush.
  function automatic logic [DSR_CNT_W-1:0] clamp_shamt(input logic [DSR_CNT_W-1:0] shamt);
    if (shamt > DSR_CNT_W'(DSR_WIDTH)) begin
      return DSR_CNT_W'(DSR_WIDTH);
    end
    return shamt;
  endfunction

endpackage

// File: rtl/seq_cmd_buffer.sv
// One-entry command holding register used when SEQ_SKID_BUFFER_EN is defined.
module seq_cmd_buffer
  import dual_shift_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  seq_cmd_t push_cmd,
  input  logic     pop,
  output logic     full,
  output seq_cmd_t cmd
);

  // Capture on push, release on pop; push wins if both occur.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      cmd  <= '0;
    end else if (push) begin
      full <= 1'b1;
      cmd  <= push_cmd;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/dual_shift_sequencer.sv
// Command sequencer driving load/shift strobes for a pair of shift registers.
// Optional one-entry command buffer enabled by defining SEQ_SKID_BUFFER_EN.
module dual_shift_sequencer
  import dual_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DSR_WIDTH,
  parameter int unsigned CNT_W = DSR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [1:0]       in_mask,
  input  logic [CNT_W-1:0] in_shamt,
  output logic             load0,
  output logic             load1,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic             shift0,
  output logic             shift1,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  seq_state_t       state_next;
  seq_cmd_t         in_cmd;
  seq_cmd_t         start_cmd;
  seq_cmd_t         cmd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start;

  // Pack the incoming command with the shift count already clamped.
  always_comb begin
    in_cmd       = '0;
    in_cmd.data0 = DSR_WIDTH'(in_data0);
    in_cmd.data1 = DSR_WIDTH'(in_data1);
    in_cmd.mask  = in_mask;
    in_cmd.shamt = clamp_shamt(DSR_CNT_W'(in_shamt));
  end

`ifdef SEQ_SKID_BUFFER_EN
  logic     buf_full;
  logic     buf_push;
  logic     buf_pop;
  seq_cmd_t buf_cmd;

  // Commands arriving while a command is in flight park in the buffer.
  assign buf_push  = in_valid && !buf_full && ((state == LOAD) || (state == SHIFT));
  assign buf_pop   = (state == DONE) && buf_full;
  assign start     = buf_pop ||
                     (in_valid && !buf_full && ((state == IDLE) || (state == DONE)));
  assign start_cmd = buf_pop ? buf_cmd : in_cmd;

  seq_cmd_buffer u_cmd_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_cmd (in_cmd),
    .pop      (buf_pop),
    .full     (buf_full),
    .cmd      (buf_cmd)
  );
`else
  assign start     = in_valid && in_ready;
  assign start_cmd = in_cmd;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Captured command and remaining shift count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      cmd_q <= start_cmd;
      cnt_q <= CNT_W'(start_cmd.shamt);
    end else if (state == SHIFT) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (cnt_q != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q <= CNT_W'(1)) state_next = DONE;
      DONE:    state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe, status and handshake decode from the current state.
  always_comb begin
    load0    = 1'b0;
    load1    = 1'b0;
    shift0   = 1'b0;
    shift1   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
`ifdef SEQ_SKID_BUFFER_EN
    in_ready = !buf_full;
`else
    in_ready = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifndef SEQ_SKID_BUFFER_EN
        in_ready = 1'b1;
`endif
      end
      LOAD: begin
        load0 = cmd_q.mask[0];
        load1 = cmd_q.mask[1];
        busy  = 1'b1;
      end
      SHIFT: begin
        shift0 = cmd_q.mask[0];
        shift1 = cmd_q.mask[1];
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
`ifndef SEQ_SKID_BUFFER_EN
        in_ready = 1'b1;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign data0 = WIDTH'(cmd_q.data0);
  assign data1 = WIDTH'(cmd_q.data1);

endmodule

// File: tb/tb_dual_shift_sequencer.sv
// Directed bench for dual_shift_sequencer with a downstream shift register model.
module tb_dual_shift_sequencer;

`ifdef SEQ_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data0 = 8'h00;
  logic [7:0] in_data1 = 8'h00;
  logic [1:0] in_mask = 2'b00;
  logic [3:0] in_shamt = 4'd0;
  logic       load0, load1, shift0, shift1, busy, done;
  logic [7:0] data0, data1;
  logic [6:0] fl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m0 = 8'h00;
  logic [7:0] m1 = 8'h00;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] mask;
    logic [3:0] shamt;
    int         nshift;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vecs[7];

  dual_shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_mask  (in_mask),
    .in_shamt (in_shamt),
    .load0    (load0),
    .load1    (load1),
    .data0    (data0),
    .data1    (data1),
    .shift0   (shift0),
    .shift1   (shift1),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign fl = {load0, load1, shift0, shift1, busy, done, in_ready};

  // Downstream register pair: load has priority, shift is logical right.
  always @(posedge clk) begin
    if (load0) m0 <= data0;
    else if (shift0) m0 <= m0 >> 1;
    if (load1) m1 <= data1;
    else if (shift1) m1 <= m1 >> 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check({tag, ":ready"}, 32'(in_ready), 32'(1'b1));
    in_data0 = v.d0;
    in_data1 = v.d1;
    in_mask  = v.mask;
    in_shamt = v.shamt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ":load"}, 32'(fl), 32'({v.mask[0], v.mask[1], 2'b00, 1'b1, 1'b0, SKID}));
    check({tag, ":ldata"}, 32'({data0, data1}), 32'({v.d0, v.d1}));
    for (int k = 0; k < v.nshift; k++) begin
      @(negedge clk);
      check({tag, ":shift"}, 32'(fl), 32'({2'b00, v.mask[0], v.mask[1], 1'b1, 1'b0, SKID}));
      check({tag, ":hold"}, 32'({data0, data1}), 32'({v.d0, v.d1}));
    end
    @(negedge clk);
    check({tag, ":done"}, 32'(fl), 32'(7'b0000011));
    @(negedge clk);
    check({tag, ":idle"}, 32'(fl), 32'(7'b0000001));
    check({tag, ":model"}, 32'({m0, m1}), 32'({v.e0, v.e1}));
  endtask

  logic [6:0] bb_exp[7];
  vec_t       rv;
  int         dones;
  logic       acc;

  initial begin
    vecs[0] = '{8'hAA, 8'h55, 2'b11, 4'd1,  1, 8'h55, 8'h2A};
    vecs[1] = '{8'h3C, 8'hC3, 2'b11, 4'd0,  0, 8'h3C, 8'hC3};
    vecs[2] = '{8'hF0, 8'h12, 2'b01, 4'd12, 8, 8'h00, 8'hC3};
    vecs[3] = '{8'h81, 8'h7E, 2'b10, 4'd3,  3, 8'h00, 8'h0F};
    vecs[4] = '{8'hFF, 8'hFF, 2'b00, 4'd2,  2, 8'h00, 8'h0F};
    vecs[5] = '{8'h80, 8'h01, 2'b11, 4'd7,  7, 8'h01, 8'h00};
    vecs[6] = '{8'hB4, 8'h2D, 2'b11, 4'd15, 8, 8'h00, 8'h00};

    bb_exp[0] = {6'b110010, SKID};
    bb_exp[1] = {6'b001110, SKID};
    bb_exp[2] = 7'b0011100;
    bb_exp[3] = {6'b000001, !SKID};
    bb_exp[4] = {6'b100010, SKID};
    bb_exp[5] = 7'b0000011;
    bb_exp[6] = 7'b0000001;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_flags", 32'(fl[6:1]), 32'(6'b000000));
    check("rst_data", 32'({data0, data1}), 32'(16'h0000));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 32'(fl), 32'(7'b0000001));

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the third shift cycle of a six-shift command.
    in_data0 = 8'h5A; in_data1 = 8'hA5; in_mask = 2'b11; in_shamt = 4'd6;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_shift", 32'(fl), 32'({6'b001110, SKID}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort", 32'(fl), 32'(7'b0000001));
    check("rst_abort_data", 32'({data0, data1}), 32'(16'h0000));
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'(0));
    rv = '{8'h0F, 8'hF0, 2'b11, 4'd4, 4, 8'h00, 8'h0F};
    run_cmd(rv, "after_rst");

    // Back-to-back: second command presented from the first shift cycle.
    in_data0 = 8'h11; in_data1 = 8'h22; in_mask = 2'b11; in_shamt = 4'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        in_data0 = 8'h33; in_data1 = 8'h44; in_mask = 2'b01; in_shamt = 4'd0;
        in_valid = 1'b1;
      end
      @(negedge clk);
      check($sformatf("b2b_c%0d", c + 1), 32'(fl), 32'(bb_exp[c]));
      if (c == 4) check("b2b_data", 32'({data0, data1}), 32'(16'h3344));
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("b2b_model", 32'({m0, m1}), 32'(16'h3308));
    check("b2b_valid_dropped", 32'(in_valid), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_shift_sequencer.md
Name: dual_shift_sequencer

Overview:
- Command sequencer that sits directly upstream of the dual 8-bit shift register pair.
- Accepts one command per valid/ready handshake. A command is two data bytes, a lane mask and a shift count.
- Drives load0/load1, data0/data1 and shift0/shift1 so the downstream registers load the bytes and then shift right the requested number of times.
- Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, data byte width per lane.
- CNT_W, 4, width of the shift-count field; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  command valid.
- in_ready  output  1  sequencer can accept a command this cycle.
- in_data0  input  WIDTH  lane-0 load value.
- in_data1  input  WIDTH  lane-1 load value.
- in_mask  input  2  lane enables; bit0 is lane 0, bit1 is lane 1.
- in_shamt  input  CNT_W  number of right shifts to issue.
- load0  output  1  lane-0 load strobe.
- load1  output  1  lane-1 load strobe.
- data0  output  WIDTH  lane-0 load data.
- data1  output  WIDTH  lane-1 load data.
- shift0  output  1  lane-0 shift strobe.
- shift1  output  1  lane-1 shift strobe.
- busy  output  1  a command is in LOAD or SHIFT.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high on rst.
- Reset values:
  - state = IDLE.
  - load0, load1, shift0, shift1, busy, done = 0.
  - data0, data1 = 0.
  - shift counter = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer, register in_data0, in_data1, in_mask and the clamped shift count.
  - Clamp rule: if in_shamt > WIDTH, use WIDTH.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: in_ready = 1. A transfer moves the FSM to LOAD.
  - LOAD (exactly one cycle):
    - load0 = mask[0], load1 = mask[1].
    - data0/data1 present the captured bytes.
    - busy = 1.
    - Next state is SHIFT if count > 0, otherwise DONE.
  - SHIFT:
    - shift0 = mask[0], shift1 = mask[1]. busy = 1.
    - Counter decrements each cycle.
    - After exactly count shift cycles, go to DONE.
  - DONE (one cycle):
    - done = 1, in_ready = 1.
    - A transfer in this cycle goes to LOAD (back-to-back). Otherwise go to IDLE.
- Timing: for a transfer at edge t:
  - load is high in cycle t+1.
  - shifts are high in cycles t+2 .. t+1+count.
  - done is high in cycle t+2+count.
- Mask 00: no strobes are issued, but the timing is identical and done still pulses.
- data0/data1 hold the last captured value until the next transfer. They do not change during SHIFT.
- Strobe exclusivity: load and shift are never both high on any lane in the same cycle.
- in_ready is 0 in LOAD and SHIFT, unless the optional feature is enabled.
- rst asserted in any state, including mid-SHIFT:
  - Next cycle is IDLE with all strobes at 0.
  - Any captured command is discarded, with no done pulse.

Optional Feature:
- Macro: SEQ_SKID_BUFFER_EN.
- When defined:
  - Adds a one-entry command buffer, and in_ready = !buffer_full in all states.
  - A command accepted during LOAD, SHIFT or DONE is held in the buffer.
  - In the DONE cycle, a buffered command goes to LOAD next; a buffered command has priority over a new transfer.
  - rst clears the buffer.
- When undefined: in_ready follows the FSM rules above, and there is no buffer logic.

Decomposition:
- Shared package dual_shift_pkg holds:
  - state enum seq_state_t {IDLE, LOAD, SHIFT, DONE}.
  - constants DSR_WIDTH = 8 and DSR_CNT_W = 4.
  - packed struct seq_cmd_t {data0, data1, mask, shamt}.
- One natural sub-module, seq_cmd_buffer: the optional one-entry skid register holding a seq_cmd_t with valid/ready.
- FSM and counter stay in the top module.

Test Plan:
- Command AA/55, mask 11, shamt 1 → load0 = load1 = 1 for one cycle with data 0xAA/0x55; one cycle of shift0 = shift1 = 1; done next cycle. A downstream register model then reads 0x55/0x2A.
- shamt 0, mask 11 → LOAD then DONE; no shift strobe ever; done at t+2.
- shamt 12 (clamped), data F0, mask 01 → exactly 8 shift0 pulses; shift1, load1 = 0 throughout; model lane 0 = 0x00.
- rst pulsed at the 3rd SHIFT cycle of shamt 6 → strobes drop the next cycle; no done; in_ready = 1; next command runs normally.
- Two commands with in_valid held high (buffer off) → second accepted in the DONE cycle; its load is in the following cycle; no idle gap.
- With SEQ_SKID_BUFFER_EN, second command issued during SHIFT → accepted immediately; runs after DONE; in_ready = 0 while the buffer is full.
